traffic_request_scheduler: RTL and testbench
============================================

Name: traffic_request_scheduler

Overview:
Front end for the traffic controller's three request buttons: left turn, north–south walk and east–west walk.
- Synchronises and debounces each active-low KEY input.
- Latches each press as a pending request.
- Grants one pending request at a time to the controller, round-robin, holding the grant until the controller reports the end of the served phase.
- Sits between the board KEYs and the traffic controller request inputs, in the clk_27 domain.

Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive stable synchronised samples needed before the debounced level changes (10 ms at 27 MHz).
- DB_CNT_W, 19: width of each debounce counter; must hold DEBOUNCE_CYCLES.
- TIMEOUT_CYCLES, 27000000: maximum grant duration when SERVE_TIMEOUT_EN is defined (1 s at 27 MHz).

Ports:
- clk_27  input  1  system clock, 27 MHz.
- reset_bar  input  1  asynchronous active-low reset.
- left_turn_request_n  input  1  raw KEY, active low, asynchronous to clk_27.
- walk_ns_request_n  input  1  raw KEY, active low, asynchronous.
- walk_ew_request_n  input  1  raw KEY, active low, asynchronous.
- phase_done  input  1  one-cycle pulse from the controller: the granted phase has completed.
- grant  output  3  one-hot grant, active high. Bit 0 = left turn, bit 1 = walk NS, bit 2 = walk EW.
- pending  output  3  latched requests not yet granted, same bit order.
- busy  output  1  high while a grant is held.
- timeout_err  output  1  one-cycle pulse on grant timeout. Tied 0 when SERVE_TIMEOUT_EN is undefined.

Behaviour:
- Reset (reset_bar low, asynchronous):
  - grant, pending, busy, timeout_err = 0.
  - Synchroniser flops and debounced levels = 1 (released).
  - Debounce counters = 0.
  - Round-robin last pointer = 2, so index 0 has first priority.
  - Reset asserted mid-SERVE drops grant immediately and discards all pending requests.
- Per input synchronisation: 2-flop synchroniser → sync level.
- Per input debounce:
  - sync == debounced level → counter cleared to 0.
  - sync != debounced level → counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes the debounced level.
- Press detect:
  - A 1→0 transition of the debounced level is a press.
  - A press sets its pending bit the following cycle.
  - A held button produces exactly one press. Release is ignored.
- FSM states: IDLE, SERVE.
- IDLE:
  - If pending != 0, select the first set bit searching from index (last+1) mod 3 upward, wrapping.
  - Next cycle: grant = one-hot(sel), pending[sel] cleared, busy = 1, last = sel, go to SERVE.
  - Latency from a pending bit set to grant: 1 cycle.
  - phase_done in IDLE is ignored.
- SERVE:
  - grant held constant.
  - On phase_done: grant = 0 and busy = 0 next cycle, return to IDLE.
  - IDLE may issue a new grant on the following cycle, so there is at least one cycle of grant = 0 between grants.
- Simultaneous events:
  - A press on index i in the same cycle pending[i] is cleared by a grant: set wins, and the request stays pending for re-service.
  - A press of the currently granted request during SERVE re-latches pending.
  - Multiple presses in one cycle set all corresponding bits.
- grant is always one-hot or zero; never more than one bit set.

Optional Feature:
SERVE_TIMEOUT_EN
- Defined:
  - A counter clears on entry to SERVE and increments each SERVE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without phase_done, then next cycle: grant = 0, busy = 0, timeout_err pulses for 1 cycle, FSM returns to IDLE. The timed-out request is not re-queued.
  - phase_done in the same cycle as the timeout terminal count: phase_done wins, timeout_err stays 0.
- Undefined: no timeout counter, timeout_err tied 0, and SERVE waits indefinitely for phase_done.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset release, all keys high for 50 cycles → grant=000, pending=000, busy=0 throughout.
- walk_ns_request_n low for 2 cycles, then high → debounced level never changes, pending stays 000.
- walk_ns_request_n held low 10 cycles → pending=010 on one cycle, then grant=010 with pending=000 the next. Pulse phase_done → grant=000 next cycle. Holding the key produces no second grant.
- All three keys pressed in the same cycle → grant sequence 001, 010, 100, each released by a phase_done pulse, with ≥1 idle cycle between grants.
- During grant=001, press left turn again → pending=001 while served. After phase_done and an EW press, the order is EW (100) then left (001), per round-robin from last=0.
- With SERVE_TIMEOUT_EN: grant walk EW, no phase_done → grant drops after 20 cycles, timeout_err=1 for 1 cycle. reset_bar low mid-SERVE → grant=000 and pending=000 asynchronously.

Source files
------------

// File: rtl/traffic_request_scheduler.sv
// Request front end for the traffic controller: synchronise and debounce three KEYs,
// latch presses, grant them round-robin one at a time. Optional macro: SERVE_TIMEOUT_EN.
module traffic_request_scheduler #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int DB_CNT_W        = 19,
  parameter int TIMEOUT_CYCLES  = 27000000
) (
  input  logic       clk_27,
  input  logic       reset_bar,
  input  logic       left_turn_request_n,
  input  logic       walk_ns_request_n,
  input  logic       walk_ew_request_n,
  input  logic       phase_done,
  output logic [2:0] grant,
  output logic [2:0] pending,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic {IDLE, SERVE} state_e;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] key_n;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level;
  logic [2:0] level_prev_q;
  logic [2:0] press;

  assign key_n = {walk_ew_request_n, walk_ns_request_n, left_turn_request_n};

  // Idle level of a KEY is high, so the synchroniser resets to "released".
  always_ff @(posedge clk_27 or negedge reset_bar) begin
    if (!reset_bar) begin
      sync1_q      <= 3'b111;
      sync2_q      <= 3'b111;
      level_prev_q <= 3'b111;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      level_prev_q <= level;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic                level_q;
    logic [DB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_27 or negedge reset_bar) begin
      if (!reset_bar) begin
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else if (sync2_q[i] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        level_q <= sync2_q[i];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level[i] = level_q;
  end

  // Only the falling edge of the debounced level counts; release is ignored.
  assign press = level_prev_q & ~level;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] pending_q, pending_d;
  logic [1:0] last_q, last_d;
  logic       timeout_q, timeout_d;
  logic [1:0] sel, idx;
  logic       found;
  logic       timed_out;

  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    idx   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

`ifdef SERVE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;

  // Held at zero in IDLE, so it starts from zero on every entry to SERVE.
  always_ff @(posedge clk_27 or negedge reset_bar) begin
    if (!reset_bar)             to_cnt_q <= '0;
    else if (state_q == SERVE)  to_cnt_q <= to_cnt_q + 1'b1;
    else                        to_cnt_q <= '0;
  end

  assign timed_out = (to_cnt_q == TO_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = SERVE;
          grant_d          = 3'b001 << sel;
          last_d           = sel;
          pending_d[sel]   = 1'b0;
        end
      end
      SERVE: begin
        if (phase_done) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (timed_out) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A press in the same cycle as its grant wins, leaving the request queued again.
    pending_d = pending_d | press;
  end

  always_ff @(posedge clk_27 or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      last_q    <= 2'd2;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign pending     = pending_q;
  assign busy        = (state_q == SERVE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_traffic_request_scheduler.sv
// Directed bench for traffic_request_scheduler with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
// Timeout checks are active when SERVE_TIMEOUT_EN is defined.
module tb_traffic_request_scheduler;

  logic       clk_27 = 1'b0;
  logic       reset_bar;
  logic       left_n, ns_n, ew_n;
  logic       phase_done;
  logic [2:0] grant, pending;
  logic       busy, timeout_err;

  int checks = 0;
  int errors = 0;

  traffic_request_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk_27             (clk_27),
    .reset_bar          (reset_bar),
    .left_turn_request_n(left_n),
    .walk_ns_request_n  (ns_n),
    .walk_ew_request_n  (ew_n),
    .phase_done         (phase_done),
    .grant              (grant),
    .pending            (pending),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk_27 = ~clk_27;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_27);
    #1;
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp);
    for (int n = 0; n < 40 && grant !== exp; n++) tick();
    check(tag, grant, exp);
  endtask

  task automatic wait_pending(input string tag, input logic [2:0] exp);
    for (int n = 0; n < 40 && pending !== exp; n++) tick();
    check(tag, pending, exp);
  endtask

  task automatic pulse_done();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  task automatic do_reset();
    {left_n, ns_n, ew_n} = 3'b111;
    phase_done = 1'b0;
    reset_bar  = 1'b0;
    repeat (2) tick();
    reset_bar = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    {left_n, ns_n, ew_n} = 3'b111;
    phase_done = 1'b0;
    reset_bar  = 1'b0;
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_pending", pending, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    repeat (2) tick();
    reset_bar = 1'b1;

    // Idle with all keys released.
    for (int n = 0; n < 50; n++) begin
      tick();
      check("idle_state", {busy, pending, grant}, 7'b0);
    end

    // Two-cycle glitch must not reach the debounced level.
    ns_n = 1'b0;
    repeat (2) tick();
    ns_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("glitch_pending", {pending, grant}, 6'b0);
    end

    // Held NS press: one pending cycle, then the grant.
    ns_n = 1'b0;
    wait_pending("ns_pending", 3'b010);
    check("ns_no_grant_yet", grant, 3'b000);
    tick();
    check("ns_grant", grant, 3'b010);
    check("ns_pending_clr", pending, 3'b000);
    check("ns_busy", busy, 1'b1);
    repeat (5) tick();
    check("ns_grant_held", grant, 3'b010);
    pulse_done();
    check("ns_release", grant, 3'b000);
    check("ns_busy_low", busy, 1'b0);
    for (int n = 0; n < 20; n++) begin
      tick();
      check("ns_held_no_regrant", {pending, grant}, 6'b0);
    end
    ns_n = 1'b1;
    repeat (10) tick();

    // All three keys in the same cycle: round-robin from index 0.
    do_reset();
    {left_n, ns_n, ew_n} = 3'b000;
    wait_pending("all_pending", 3'b111);
    tick();
    check("all_g0", grant, 3'b001);
    check("all_p0", pending, 3'b110);
    pulse_done();
    check("all_gap0", grant, 3'b000);
    tick();
    check("all_g1", grant, 3'b010);
    check("all_p1", pending, 3'b100);
    pulse_done();
    check("all_gap1", grant, 3'b000);
    tick();
    check("all_g2", grant, 3'b100);
    check("all_p2", pending, 3'b000);
    pulse_done();
    check("all_done", {busy, grant}, 4'b0);
    {left_n, ns_n, ew_n} = 3'b111;
    repeat (10) tick();

    // Re-press of the granted request, then EW ahead of left from last=0.
    do_reset();
    left_n = 1'b0;
    wait_grant("rp_grant_left", 3'b001);
    left_n = 1'b1;
    repeat (10) tick();
    left_n = 1'b0;
    wait_pending("rp_relatch", 3'b001);
    check("rp_still_left", grant, 3'b001);
    ew_n = 1'b0;
    wait_pending("rp_both", 3'b101);
    pulse_done();
    check("rp_gap", grant, 3'b000);
    tick();
    check("rp_ew_first", grant, 3'b100);
    check("rp_left_waits", pending, 3'b001);
    pulse_done();
    tick();
    check("rp_left_second", grant, 3'b001);
    check("rp_empty", pending, 3'b000);
    {left_n, ns_n, ew_n} = 3'b111;
    pulse_done();
    repeat (10) tick();

    // Grant held with no phase_done.
    do_reset();
    ew_n = 1'b0;
    wait_grant("to_grant_ew", 3'b100);
`ifdef SERVE_TIMEOUT_EN
    cnt = 0;
    while (grant == 3'b100 && cnt < 60) begin
      check("to_no_err_early", timeout_err, 1'b0);
      cnt++;
      tick();
    end
    check("to_duration", cnt, 20);
    check("to_err_pulse", timeout_err, 1'b1);
    check("to_grant_drop", {busy, grant}, 4'b0);
    check("to_not_requeued", pending, 3'b000);
    tick();
    check("to_err_one_cycle", timeout_err, 1'b0);
    check("to_stays_idle", grant, 3'b000);
`else
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (grant == 3'b100 && timeout_err == 1'b0) cnt++;
    end
    check("no_to_held", cnt, 40);
    pulse_done();
    check("no_to_release", grant, 3'b000);
`endif
    ew_n = 1'b1;
    repeat (10) tick();

    // Asynchronous reset in the middle of SERVE with a request pending.
    do_reset();
    ns_n = 1'b0;
    wait_grant("ar_grant_ns", 3'b010);
    left_n = 1'b0;
    wait_pending("ar_pending", 3'b001);
    #3;
    reset_bar = 1'b0;
    #1;
    check("ar_grant", grant, 3'b000);
    check("ar_pending_clr", pending, 3'b000);
    check("ar_busy", busy, 1'b0);
    {left_n, ns_n, ew_n} = 3'b111;
    tick();
    reset_bar = 1'b1;
    repeat (5) tick();
    check("ar_after", {busy, pending, grant}, 7'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
